// File: rtl/writeback_buffered_if.sv
// rtl/writeback_buffered_if.sv - MEM-stage, register-file and forwarding signals of writeback_buffered
interface writeback_buffered_if #(
  parameter int REG_WIDTH = 32,
  parameter int REG_BITS  = 5
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_write_en;
  logic [REG_BITS-1:0]         in_write_reg;
  logic [REG_WIDTH-1:0]        in_alu_out;
  logic [REG_WIDTH-1:0]        in_mem_data;
  logic [REG_WIDTH-1:0]        in_return_pc;
  logic [1:0]                  in_src_sel;
  logic [2:0]                  in_load_type;
  logic [1:0]                  in_byte_off;
  logic                        rf_ready;
  logic                        write_en;
  logic [REG_BITS-1:0]         write_reg;
  logic signed [REG_WIDTH-1:0] write_data;
  logic [31:0]                 retire_count;
  logic [REG_BITS-1:0]         fwd_reg;
  logic                        fwd_hit;
  logic [REG_WIDTH-1:0]        fwd_data;

  modport master (
    output in_valid, in_write_en, in_write_reg, in_alu_out, in_mem_data, in_return_pc,
           in_src_sel, in_load_type, in_byte_off, rf_ready, fwd_reg,
    input  in_ready, write_en, write_reg, write_data, retire_count, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_write_en, in_write_reg, in_alu_out, in_mem_data, in_return_pc,
           in_src_sel, in_load_type, in_byte_off, rf_ready, fwd_reg,
    output in_ready, write_en, write_reg, write_data, retire_count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/writeback_buffered.sv
// rtl/writeback_buffered.sv - writeback stage with an in-order FIFO in front of the register file
// Optional youngest-entry forwarding query enabled by macro WRITEBACK_FORWARD_EN.
module writeback_buffered #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int DEPTH     = 2,
  parameter int REG_BITS  = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  writeback_buffered_if.slave  bus
);
  localparam int PTR_BITS = $clog2(DEPTH);

  logic [REG_BITS-1:0]  r_reg_mem  [DEPTH];
  logic [REG_WIDTH-1:0] r_data_mem [DEPTH];
  logic [PTR_BITS-1:0]  r_wr_ptr;
  logic [PTR_BITS-1:0]  r_rd_ptr;
  logic [PTR_BITS:0]    r_count;
  logic [31:0]          r_retire;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [REG_WIDTH-1:0] w_load;
  logic [REG_WIDTH-1:0] w_data;

  assign w_nonempty   = (r_count != '0);
  assign bus.in_ready = (r_count < (PTR_BITS+1)'(DEPTH));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_push       = w_accept && bus.in_write_en && (bus.in_write_reg != '0);
  assign w_pop        = w_nonempty && bus.rf_ready;

  // Halfword lane uses only byte_off[1]; misaligned bit 0 is ignored.
  assign w_byte = bus.in_mem_data[{bus.in_byte_off, 3'b000} +: 8];
  assign w_half = bus.in_mem_data[{bus.in_byte_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = bus.in_mem_data;
    case (bus.in_load_type)
      3'b000:  w_load = {{(REG_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(REG_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(REG_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(REG_WIDTH-16){1'b0}}, w_half};
      default: w_load = bus.in_mem_data;
    endcase
  end

  always_comb begin
    w_data = bus.in_alu_out;
    case (bus.in_src_sel)
      2'd1:    w_data = w_load;
      2'd2:    w_data = bus.in_return_pc;
      default: w_data = bus.in_alu_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg_mem[r_wr_ptr]  <= bus.in_write_reg;
      r_data_mem[r_wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_retire <= '0;
    end else begin
      if (w_accept) r_retire <= r_retire + 32'd1;
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.retire_count = r_retire;
  assign bus.write_en     = w_nonempty;
  assign bus.write_reg    = w_nonempty ? r_reg_mem[r_rd_ptr]  : '0;
  assign bus.write_data   = w_nonempty ? r_data_mem[r_rd_ptr] : '0;

`ifdef WRITEBACK_FORWARD_EN
  logic [PTR_BITS-1:0] w_fidx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    w_fidx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fidx = r_rd_ptr + PTR_BITS'(i);
      if (((PTR_BITS+1)'(i) < r_count) && (bus.fwd_reg != '0) &&
          (r_reg_mem[w_fidx] == bus.fwd_reg)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = r_data_mem[w_fidx];
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^bus.fwd_reg;
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif
endmodule
